// File: rtl/mem_access_unit.sv
// Load/store unit between the multicycle datapath and a word-wide, byte-enable-less data memory.
// Optional MISALIGN_TRAP_EN enables misalignment/illegal-funct3 error reporting.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    size_t               size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_out_q, err_out_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;

    size_t               req_size;
    logic                req_uns;
    logic                req_err;

    // Lane extraction and sign/zero extension of a load from the fetched word.
    function automatic logic [DATA_W-1:0] load_ext(
        input logic [DATA_W-1:0] word,
        input size_t             size,
        input logic              uns,
        input logic [1:0]        lo
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        res = word;
        unique case (size)
            SZ_B: begin
                sh  = word >> {lo, 3'b000};
                res = uns ? DATA_W'(sh[7:0]) : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                sh  = word >> {lo[1], 4'b0000};
                res = uns ? DATA_W'(sh[15:0]) : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half lane of the old word with the store data.
    function automatic logic [DATA_W-1:0] merge_lane(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] wdata,
        input size_t             size,
        input logic [1:0]        lo
    );
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] ins;
        if (size == SZ_B) begin
            mask = DATA_W'(32'h0000_00FF) << {lo, 3'b000};
            ins  = DATA_W'(wdata[7:0]) << {lo, 3'b000};
        end else begin
            mask = DATA_W'(32'h0000_FFFF) << {lo[1], 4'b0000};
            ins  = DATA_W'(wdata[15:0]) << {lo[1], 4'b0000};
        end
        return (old_word & ~mask) | ins;
    endfunction

    // Request decode: access size, extension and (optionally) the error check.
    always_comb begin
        req_size = SZ_W;
        req_uns  = 1'b0;
        req_err  = 1'b0;
        unique case (funct3_i)
            3'b000:  req_size = SZ_B;
            3'b001:  req_size = SZ_H;
            3'b010:  req_size = SZ_W;
            3'b100: begin
                req_size = SZ_B;
                req_uns  = 1'b1;
            end
            3'b101: begin
                req_size = SZ_H;
                req_uns  = 1'b1;
            end
            default: req_size = SZ_W;
        endcase
`ifdef MISALIGN_TRAP_EN
        req_err = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111)
               || (we_i && (funct3_i == 3'b100 || funct3_i == 3'b101))
               || (req_size == SZ_H && addr_i[0])
               || (req_size == SZ_W && addr_i[1:0] != 2'b00);
`endif
    end

    // Next-state, request latching and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_out_d = 1'b0;
        mem_we_d  = 1'b0;
        mem_a_d   = '0;
        mem_wd_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = req_size;
                    uns_d   = req_uns;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    err_d   = req_err;
                    state_d = req_err ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_ext(mem_rd_i, size_q, uns_q, addr_q[1:0]);
                    state_d = S_DONE;
                end else if (size_q == SZ_W) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        err_out_d = (state_d == S_DONE) && err_d;

        if (state_d == S_ACCESS || state_d == S_WRITE) begin
            mem_a_d = {addr_d[ADDR_W-1:2], 2'b00};
        end
        // Word store writes straight from ACCESS; sub-word stores merge the word fetched in ACCESS.
        if (state_d == S_ACCESS && we_d && size_d == SZ_W) begin
            mem_we_d = 1'b1;
            mem_wd_d = wdata_d;
        end else if (state_d == S_WRITE) begin
            mem_we_d = 1'b1;
            mem_wd_d = merge_lane(mem_rd_i, wdata_q, size_q, addr_q[1:0]);
        end
    end

    // State and output registers; reset aborts any pending write at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_out_q <= err_out_d;
            mem_we_q  <= mem_we_d;
            mem_a_q   <= mem_a_d;
            mem_wd_q  <= mem_wd_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_out_q;
    assign mem_we_o = mem_we_q;
    assign mem_a_o  = mem_a_q;
    assign mem_wd_o = mem_wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level memory model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .req_i    (req),
        .we_i     (we),
        .funct3_i (funct3),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .busy_o   (busy),
        .done_o   (done),
        .rdata_o  (rdata),
        .err_o    (err),
        .mem_we_o (mem_we),
        .mem_a_o  (mem_a),
        .mem_wd_o (mem_wd),
        .mem_rd_i (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Predict the outcome from the access rules, then run it and compare.
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input bit hold);
        int unsigned idx, sz, off;
        logic [31:0] word, mask, val;
        bit          illegal, mis, e;
        int          exp_lat, exp_wes, exp_wecyc, lat, wes, wecyc;

        idx     = a[7:2];
        word    = ref_mem[idx];
        illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) || (w && (f3 == 3'b100 || f3 == 3'b101));
        sz      = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        mis     = (a % sz) != 0;
`ifdef MISALIGN_TRAP_EN
        e = illegal || mis;
`else
        e = 1'b0;
`endif
        off  = a % 4;
        off  = off - (off % sz);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        if (!e && !w) begin
            val = (word >> (8 * off)) & mask;
            if ((f3 == 3'b000 || f3 == 3'b001) && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
            exp_rdata = val;
        end
        if (!e && w) ref_mem[idx] = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        exp_lat   = e ? 1 : (!w || sz == 4) ? 2 : 3;
        exp_wes   = (!e && w) ? 1 : 0;
        exp_wecyc = (sz == 4) ? 1 : 2;

        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        lat = 0; wes = 0; wecyc = 0;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        chk("busy", 32'(busy), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin
                wes++;
                wecyc = c;
            end
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(err), 32'(e));
        chk("rdata", rdata, exp_rdata);
        chk("we_count", 32'(wes), 32'(exp_wes));
        if (exp_wes == 1) chk("we_cycle", 32'(wecyc), 32'(exp_wecyc));
        @(posedge clk); #1;
        if (hold) req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("idle", {30'd0, busy, done}, 32'd0);
            @(posedge clk); #1;
        end
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic set_word(input int unsigned idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
        exp_rdata = '0;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err_we", {29'd0, done, err, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        set_word(4, 32'h80FF_7F01);
        run_txn(1'b0, 3'b000, 32'h13, '0, 1'b0);
        chk("lb_const", rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h13, '0, 1'b0);
        chk("lbu_const", rdata, 32'h0000_0080);
        run_txn(1'b0, 3'b001, 32'h12, '0, 1'b0);
        chk("lh_const", rdata, 32'hFFFF_80FF);
        run_txn(1'b0, 3'b101, 32'h10, '0, 1'b0);
        chk("lhu_const", rdata, 32'h0000_7F01);
        run_txn(1'b0, 3'b010, 32'h10, '0, 1'b0);
        chk("lw_const", rdata, 32'h80FF_7F01);

        set_word(4, 32'h1122_3344);
        run_txn(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 1'b0);
        chk("sb_const", mem[4], 32'h1122_AB44);

        run_txn(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b1);
        run_txn(1'b0, 3'b010, 32'h20, '0, 1'b0);
        chk("sw_readback", rdata, 32'hDEAD_BEEF);

        run_txn(1'b0, 3'b010, 32'h22, '0, 1'b0);

        // Reset in the write cycle of a halfword read-modify-write.
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h32; wdata = 32'h0000_CAFE;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rmw_we_before", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_we_drop", 32'(mem_we), 32'd0);
        chk("rst_busy_drop", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rdata = '0;
        for (int c = 0; c < 3; c++) begin
            chk("rst_no_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        chk("rst_word_kept", mem[12], ref_mem[12]);
        chk("rst_rdata_clr", rdata, 32'd0);

        for (int n = 0; n < 200; n++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'($urandom_range(0, 255)), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
